excess3_serial_rx: RTL and testbench

Upstream feeder for the excess-3 to BCD converter. It deserializes a bit-serial stream of excess-3 digits (4 bits per digit, framed into DIGITS-digit words) into a registered 4-bit parallel digit. It presents each digit on a valid/ready handshake and flags codes outside the legal excess-3 range 0011..1100. Its e output connects directly to the converter's e input.

---
 rtl/excess3_serial_rx_pkg.sv | 13 +
 rtl/excess3_serial_rx_e3_range_check.sv | 11 +
 rtl/excess3_serial_rx.sv | 93 +++++++++
 tb/tb_excess3_serial_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/excess3_serial_rx_pkg.sv
// excess3_serial_rx_pkg: shared state encodings and excess-3 code limits
//   IDLE/SHIFT/HOLD  receiver FSM states
//   E3_MIN/E3_MAX    legal excess-3 code range (decimal 0..9)
//   E3_ZERO          excess-3 encoding of decimal zero, the idle value of e
package excess3_serial_rx_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t HOLD  = 2'd2;
    localparam logic [3:0] E3_MIN  = 4'b0011;
    localparam logic [3:0] E3_MAX  = 4'b1100;
    localparam logic [3:0] E3_ZERO = 4'b0011;
endpackage

// File: rtl/excess3_serial_rx_e3_range_check.sv
// e3_range_check: flags a 4-bit code outside the legal excess-3 range
//   e    in   4-bit candidate excess-3 code
//   err  out  1 when e is 0000..0010 or 1101..1111
module e3_range_check
    import excess3_serial_rx_pkg::*;
(
    input  logic [3:0] e,
    output logic       err
);
    assign err = (e < E3_MIN) || (e > E3_MAX);
endmodule

// File: rtl/excess3_serial_rx.sv
// excess3_serial_rx: deserializes framed bit-serial excess-3 digits onto a valid/ready port
//   clk, rst           clock, asynchronous active-high reset
//   sync               synchronous frame resync, drops any partial digit/frame
//   sin, sin_valid     serial bit input; sin_ready low only while a digit waits
//   e, e_valid, e_ready  assembled digit and its handshake
//   e_err              e is not a legal excess-3 code
//   e_last             e is the final digit of its frame
module excess3_serial_rx
    import excess3_serial_rx_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       sin,
    input  logic       sin_valid,
    output logic       sin_ready,
    output logic [3:0] e,
    output logic       e_valid,
    input  logic       e_ready,
    output logic       e_err,
    output logic       e_last
);
    localparam int DW = $clog2(DIGITS + 1);
    localparam logic [DW-1:0] LAST_IDX = DW'(DIGITS - 1);

    state_t        state;
    logic [1:0]    bcnt;
    logic [DW-1:0] dcnt;
    logic [3:0]    sreg;
    logic [3:0]    next_digit;
    logic          next_err;
    logic [1:0]    pos;
    logic          take;

    assign sin_ready = state != HOLD;
    assign e_valid   = state == HOLD;
    assign take      = sin_valid && sin_ready;
    assign pos       = LSB_FIRST ? bcnt : 2'd3 - bcnt;

    // Digit as it will look once the current bit is merged in; on the 4th
    // bit this is loaded straight into e so the digit appears one edge early.
    always_comb begin
        next_digit      = sreg;
        next_digit[pos] = sin;
    end

    e3_range_check u_chk (
        .e   (next_digit),
        .err (next_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bcnt   <= 2'd0;
            dcnt   <= '0;
            sreg   <= 4'd0;
            e      <= E3_ZERO;
            e_err  <= 1'b0;
            e_last <= 1'b0;
        end else if (sync) begin
            state <= IDLE;
            bcnt  <= 2'd0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    sreg  <= next_digit;
                    bcnt  <= 2'd1;
                    state <= SHIFT;
                end
                SHIFT: if (take) begin
                    sreg <= next_digit;
                    bcnt <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        e      <= next_digit;
                        e_err  <= next_err;
                        e_last <= dcnt == LAST_IDX;
                        state  <= HOLD;
                    end
                end
                HOLD: if (e_ready) begin
                    state <= IDLE;
                    dcnt  <= dcnt == LAST_IDX ? '0 : dcnt + DW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_excess3_serial_rx.sv
// tb_excess3_serial_rx: scoreboard bench for excess3_serial_rx (LSB-first and MSB-first instances)
module tb_excess3_serial_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       e_ready = 1'b0;
    logic       sin_ready, e_valid, e_err, e_last;
    logic [3:0] e;
    logic       sin_ready_m, e_valid_m, e_err_m, e_last_m;
    logic [3:0] e_m;

    typedef struct {
        logic [3:0] e;
        logic       err;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   idx = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    excess3_serial_rx #(.DIGITS(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .sync(sync), .sin(sin), .sin_valid(sin_valid),
        .sin_ready(sin_ready), .e(e), .e_valid(e_valid), .e_ready(e_ready),
        .e_err(e_err), .e_last(e_last)
    );

    excess3_serial_rx #(.DIGITS(4), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .sync(sync), .sin(sin), .sin_valid(sin_valid),
        .sin_ready(sin_ready_m), .e(e_m), .e_valid(e_valid_m), .e_ready(e_ready),
        .e_err(e_err_m), .e_last(e_last_m)
    );

    task automatic push_exp(input logic [3:0] d);
        q.push_back('{d, (d < 4'd3) || (d > 4'd12), idx == 3});
    endtask

    // b[0] is the first bit on the wire
    task automatic send_bits(input logic [3:0] b);
        for (int k = 0; k < 4; k++) begin
            sin = b[k];
            sin_valid = 1'b1;
            for (int n = 0; !sin_ready && n < 20; n++) @(negedge clk);
            if (!sin_ready) begin
                total++; bad++;
                $display("FAIL send_ready got=0 want=1");
            end
            @(negedge clk);
        end
        sin_valid = 1'b0;
    endtask

    task automatic expect_digit(input string name);
        exp_t x;
        for (int n = 0; !e_valid && n < 20; n++) @(negedge clk);
        total++;
        if (e_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s e_valid got=%b want=1", name, e_valid);
        end
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            x = q.pop_front();
            if ({e, e_err, e_last} !== {x.e, x.err, x.last}) begin
                bad++;
                $display("FAIL %s e/err/last got=%b/%b/%b want=%b/%b/%b",
                         name, e, e_err, e_last, x.e, x.err, x.last);
            end
        end
        e_ready = 1'b1;
        @(negedge clk);
        e_ready = 1'b0;
        total++;
        if (e_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s e_valid_after got=%b want=0", name, e_valid);
        end
        idx = (idx + 1) % 4;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        idx = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({e, e_valid, e_err, e_last, sin_ready} !== {4'b0011, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset e/v/err/last/rdy got=%b/%b/%b/%b/%b want=0011/0/0/0/1",
                     e, e_valid, e_err, e_last, sin_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        push_exp(4'b0101);
        send_bits(4'b0101);
        total++;
        if (e_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency e_valid got=%b want=1", e_valid);
        end
        total++;
        if (4'(e - 4'd3) !== 4'd2) begin
            bad++;
            $display("FAIL converter got=%b want=0010", 4'(e - 4'd3));
        end
        expect_digit("basic");
    endtask

    task automatic test_frame();
        logic [3:0] ds[5] = '{4'b0011, 4'b0111, 4'b1001, 4'b1100, 4'b0101};
        do_sync();
        foreach (ds[i]) begin
            push_exp(ds[i]);
            send_bits(ds[i]);
            expect_digit($sformatf("frame%0d", i));
        end
    endtask

    task automatic test_errors();
        logic [3:0] ds[4] = '{4'b1110, 4'b0000, 4'b0100, 4'b0011};
        do_sync();
        foreach (ds[i]) begin
            push_exp(ds[i]);
            send_bits(ds[i]);
            expect_digit($sformatf("err%0d", i));
        end
    endtask

    task automatic test_backpressure();
        exp_t x;
        push_exp(4'b1000);
        send_bits(4'b1000);
        sin = 1'b1;
        sin_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({sin_ready, e_valid, e} !== {1'b0, 1'b1, 4'b1000}) begin
                bad++;
                $display("FAIL hold%0d rdy/v/e got=%b/%b/%b want=0/1/1000", c, sin_ready, e_valid, e);
            end
        end
        x = q.pop_front();
        total++;
        if ({e, e_err, e_last} !== {x.e, x.err, x.last}) begin
            bad++;
            $display("FAIL hold_digit got=%b/%b/%b want=%b/%b/%b", e, e_err, e_last, x.e, x.err, x.last);
        end
        e_ready = 1'b1;
        @(negedge clk);
        e_ready = 1'b0;
        idx = (idx + 1) % 4;
        total++;
        if ({e_valid, sin_ready} !== 2'b01) begin
            bad++;
            $display("FAIL release v/rdy got=%b/%b want=0/1", e_valid, sin_ready);
        end
        push_exp(4'b0100);
        send_bits(4'b0100);
        expect_digit("after_hold");
    endtask

    task automatic test_sync();
        do_sync();
        sin_valid = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        sin = 1'b0;
        @(negedge clk);
        sync = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        sin_valid = 1'b0;
        idx = 0;
        total++;
        if ({sin_ready, e_valid} !== 2'b10) begin
            bad++;
            $display("FAIL sync_partial rdy/v got=%b/%b want=1/0", sin_ready, e_valid);
        end
        push_exp(4'b0110);
        send_bits(4'b0110);
        expect_digit("sync_first");
        send_bits(4'b1010);
        total++;
        if (e_valid !== 1'b1) begin
            bad++;
            $display("FAIL sync_hold_pre e_valid got=%b want=1", e_valid);
        end
        do_sync();
        total++;
        if ({e_valid, e} !== {1'b0, 4'b1010}) begin
            bad++;
            $display("FAIL sync_hold v/e got=%b/%b want=0/1010", e_valid, e);
        end
        for (int i = 0; i < 4; i++) begin
            push_exp(4'(i + 3));
            send_bits(4'(i + 3));
            expect_digit($sformatf("post_sync%0d", i));
        end
    endtask

    task automatic test_async_reset_msb();
        sin_valid = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        sin = 1'b0;
        @(negedge clk);
        sin_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({e, e_valid, sin_ready, e_m, e_valid_m} !== {4'b0011, 1'b0, 1'b1, 4'b0011, 1'b0}) begin
            bad++;
            $display("FAIL async_rst e/v/rdy/e_m/v_m got=%b/%b/%b/%b/%b want=0011/0/1/0011/0",
                     e, e_valid, sin_ready, e_m, e_valid_m);
        end
        @(negedge clk);
        rst = 1'b0;
        idx = 0;
        q.delete();
        push_exp(4'b1001);
        send_bits(4'b1001);
        total++;
        if ({e_m, e_valid_m, e_err_m, e_last_m} !== {4'b1001, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL msb_1001 e/v/err/last got=%b/%b/%b/%b want=1001/1/0/0",
                     e_m, e_valid_m, e_err_m, e_last_m);
        end
        expect_digit("msb_a");
        push_exp(4'b0011);
        send_bits(4'b0011);
        total++;
        if ({e_m, e_err_m, e_last_m} !== {4'b1100, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL msb_1100 e/err/last got=%b/%b/%b want=1100/0/0", e_m, e_err_m, e_last_m);
        end
        expect_digit("msb_b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame();
        test_errors();
        test_backpressure();
        test_sync();
        test_async_reset_msb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
